// File: rtl/policy_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : policy_scheduler_pkg
//  Description : Shared constants and state encoding for the policy scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package policy_scheduler_pkg;

    localparam int              WORD_WIDTH = 16;
    localparam logic [15:0]     OPBASE     = 16'h0600;
    localparam logic [15:0]     NO_HOP     = 16'd100;
    localparam logic [15:0]     EPS_RESET  = 16'd15;
    localparam logic [7:0]      WD_LIMIT   = 8'd255;
    localparam logic [2:0]      FETCH_LAST = 3'd4;

    typedef enum logic [7:0] {
        ST_IDLE   = 8'd0,
        ST_FETCH  = 8'd1,
        ST_PRST   = 8'd2,
        ST_RUN    = 8'd3,
        ST_UPDATE = 8'd4,
        ST_DONE   = 8'd5
    } state_t;

    // Epsilon decay that never wraps below zero.
    function automatic logic [WORD_WIDTH-1:0] eps_decay(
        input logic [WORD_WIDTH-1:0] eps,
        input logic [WORD_WIDTH-1:0] step
    );
        return (eps < step) ? '0 : (eps - step);
    endfunction

endpackage
`default_nettype wire

// File: rtl/policy_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : policy_scheduler
//  Description : Fetches policy operands, runs an external policy block under
//                a watchdog, and records its decision with epsilon decay.
//  Revision    : 1.0 - initial release
// ============================================================================
module policy_scheduler
    import policy_scheduler_pkg::*;
(
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  eps_load,
    input  logic [WORD_WIDTH-1:0] epsilon_init,
    input  logic [WORD_WIDTH-1:0] epsilon_step,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] wp_address,
    output logic                  wp_nreset,
    output logic                  wp_start,
    input  logic                  wp_done,
    input  logic [WORD_WIDTH-1:0] wp_nexthop,
    output logic [WORD_WIDTH-1:0] op_mybest,
    output logic [WORD_WIDTH-1:0] op_besthop,
    output logic [WORD_WIDTH-1:0] op_bestvalue,
    output logic [WORD_WIDTH-1:0] op_bestneighborID,
    output logic [WORD_WIDTH-1:0] epsilon,
    output logic [WORD_WIDTH-1:0] nexthop,
    output logic                  done,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [7:0]            cstate
);

    state_t                  r_state;
    state_t                  w_next;
    logic [2:0]              r_k;
    logic [7:0]              r_wd;
    logic [WORD_WIDTH-1:0]   r_addr_hold;
    logic [WORD_WIDTH-1:0]   r_mybest;
    logic [WORD_WIDTH-1:0]   r_besthop;
    logic [WORD_WIDTH-1:0]   r_bestvalue;
    logic [WORD_WIDTH-1:0]   r_bestnbr;
    logic [WORD_WIDTH-1:0]   r_eps;
    logic [WORD_WIDTH-1:0]   r_nexthop;
    logic [WORD_WIDTH-1:0]   r_hop_cap;
    logic                    r_run_ok;
    logic                    r_timeout;
    logic                    r_done;
    logic                    r_busy;
    logic                    r_wp_start;
    logic                    r_wp_nreset;
    logic [WORD_WIDTH-1:0]   w_fetch_addr;
    logic                    w_fetch_issue;

    assign w_fetch_addr  = OPBASE + {12'd0, r_k, 1'b0};
    assign w_fetch_issue = (r_state == ST_FETCH) && (r_k < FETCH_LAST);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // A simultaneous load request takes priority and drops start.
                if (eps_load) begin
                    w_next = ST_IDLE;
                end else if (start) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (r_k == FETCH_LAST) begin
                    w_next = ST_PRST;
                end
            end
            ST_PRST: begin
                w_next = ST_RUN;
            end
            ST_RUN: begin
                if (wp_done || (r_wd == (WD_LIMIT - 8'd1))) begin
                    w_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_wp_start  <= 1'b0;
            r_wp_nreset <= 1'b0;
        end else begin
            r_done      <= (w_next == ST_DONE);
            r_busy      <= (w_next != ST_IDLE);
            r_wp_start  <= (w_next == ST_RUN);
            r_wp_nreset <= (w_next != ST_PRST);
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_k         <= '0;
            r_wd        <= '0;
            r_addr_hold <= '0;
            r_mybest    <= '0;
            r_besthop   <= '0;
            r_bestvalue <= '0;
            r_bestnbr   <= '0;
            r_eps       <= EPS_RESET;
            r_nexthop   <= NO_HOP;
            r_hop_cap   <= '0;
            r_run_ok    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_k <= '0;
                    if (eps_load) begin
                        r_eps <= epsilon_init;
                    end
                end
                ST_FETCH: begin
                    if (w_fetch_issue) begin
                        r_addr_hold <= w_fetch_addr;
                    end
                    // Read data trails the address by one cycle.
                    case (r_k)
                        3'd1:    r_mybest    <= data_in;
                        3'd2:    r_besthop   <= data_in;
                        3'd3:    r_bestvalue <= data_in;
                        3'd4:    r_bestnbr   <= data_in;
                        default: ;
                    endcase
                    r_k <= r_k + 3'd1;
                end
                ST_PRST: begin
                    r_k  <= '0;
                    r_wd <= '0;
                end
                ST_RUN: begin
                    r_wd      <= r_wd + 8'd1;
                    r_run_ok  <= wp_done;
                    r_hop_cap <= wp_nexthop;
                end
                ST_UPDATE: begin
                    if (r_run_ok) begin
                        r_nexthop <= r_hop_cap;
                        r_timeout <= 1'b0;
                        r_eps     <= eps_decay(r_eps, epsilon_step);
                    end else begin
                        r_nexthop <= NO_HOP;
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        address = r_addr_hold;
        if (r_state == ST_RUN) begin
            address = wp_address;
        end else if (w_fetch_issue) begin
            address = w_fetch_addr;
        end
    end

    assign wp_nreset         = r_wp_nreset;
    assign wp_start          = r_wp_start;
    assign op_mybest         = r_mybest;
    assign op_besthop        = r_besthop;
    assign op_bestvalue      = r_bestvalue;
    assign op_bestneighborID = r_bestnbr;
    assign epsilon           = r_eps;
    assign nexthop           = r_nexthop;
    assign done              = r_done;
    assign busy              = r_busy;
    assign timeout_err       = r_timeout;
    assign cstate            = r_state;

endmodule
`default_nettype wire

// File: doc/policy_scheduler.md
POLICY_SCHEDULER -- requirements
Module: policy_scheduler

Interface
REQ-001 Port `clock`, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 Port `nreset`, input, 1 bit: asynchronous, active-low reset.
REQ-003 Port `start`, input, 1 bit: pulse that requests one policy decision; sampled only in IDLE.
REQ-004 Port `eps_load`, input, 1 bit: loads `epsilon_init` into the epsilon register; sampled only in IDLE.
REQ-005 Port `epsilon_init`, input, 16 bits: epsilon load value.
REQ-006 Port `epsilon_step`, input, 16 bits: per-decision epsilon decay.
REQ-007 Port `data_in`, input, 16 bits: shared memory read data, valid one cycle after `address` changes.
REQ-008 Port `address`, output, 16 bits: shared memory read address, muxed between this block and the policy.
REQ-009 Port `wp_address`, input, 16 bits: policy-requested memory address.
REQ-010 Port `wp_nreset`, output, 1 bit: policy-local active-low reset pulse.
REQ-011 Port `wp_start`, output, 1 bit: policy start.
REQ-012 Port `wp_done`, input, 1 bit: policy done.
REQ-013 Port `wp_nexthop`, input, 16 bits: policy result.
REQ-014 Ports `op_mybest`, `op_besthop`, `op_bestvalue`, `op_bestneighborID`, outputs, 16 bits each: registered policy operands.
REQ-015 Port `epsilon`, output, 16 bits: current epsilon presented to the policy.
REQ-016 Port `nexthop`, output, 16 bits: last decision.
REQ-017 Ports `done`, `busy`, `timeout_err`, outputs, 1 bit each: completion, activity and error status.
REQ-018 Port `cstate`, output, 8 bits: current state encoding, for debug.

Function
REQ-019 States SHALL be IDLE=0, FETCH=1, PRST=2, RUN=3, UPDATE=4, DONE=5.
- Any other encoding SHALL return to IDLE on the next clock.
REQ-020 IDLE behaviour:
- `eps_load`=1 loads `epsilon_init` and stays in IDLE.
- Otherwise `start`=1 goes to FETCH.
- If `eps_load` and `start` are both 1, the load wins and `start` is dropped.
REQ-021 FETCH SHALL run 5 cycles using a fetch counter k=0..4.
- For k=0..3, `address` = OPBASE + 2k.
- For k=1..4, `data_in` is captured into the operand fetched at k-1, in the order mybest, besthop, bestvalue, bestneighborID.
REQ-022 PRST SHALL last exactly 1 cycle with `wp_nreset`=0; `wp_nreset`=1 in every other state.
REQ-023 RUN behaviour:
- `wp_start`=1 is held and `address`=`wp_address`.
- The first cycle with `wp_done`=1 goes to UPDATE with `timeout_err` cleared.
- In every other state `address` holds the last FETCH address or 0.
REQ-024 RUN watchdog: an 8-bit counter cleared on entry to RUN.
- If 255 RUN cycles pass without `wp_done`, go to UPDATE with `timeout_err` set.
REQ-025 UPDATE on success:
- `nexthop` <= `wp_nexthop`.
- epsilon <= epsilon - `epsilon_step`, saturating at 0 when epsilon < `epsilon_step`.
REQ-026 UPDATE on timeout: `nexthop` <= NO_HOP (100); epsilon is unchanged.
REQ-027 DONE SHALL assert `done`=1 for exactly one cycle, then go to IDLE.
REQ-028 Decision latency (start sampled to `done` high) SHALL be 5 + 1 + N + 1 + 1 cycles, where N = number of RUN cycles.
REQ-029 `busy` SHALL be 1 in every state except IDLE; `start` while busy is ignored and not queued.
REQ-030 `timeout_err` and `nexthop` SHALL hold their values until the next UPDATE.

Reset
REQ-031 `nreset`=0 SHALL immediately set:
- state to IDLE;
- all operands, `address`, and the fetch and watchdog counters to 0;
- epsilon to EPS_RESET (15);
- `nexthop` to NO_HOP (100);
- `done`, `busy`, `wp_start`, `timeout_err` to 0;
- `wp_nreset` to 0.
REQ-032 A reset asserted mid-decision SHALL abandon the decision without asserting `done`; after release the block is in IDLE with reset values.

Structure
REQ-033 A shared package SHALL hold: WORD_WIDTH=16, OPBASE=16'h600, NO_HOP=16'd100, EPS_RESET=16'd15, WD_LIMIT=8'd255, and the state encodings.
REQ-034 The block SHALL be a single module with no sub-modules; the policy block is instantiated alongside it by the parent.

Verification
REQ-035 Fetch and success path:
- Stimulus: memory 0x600/602/604/606 = 0x0050/0x0003/0x0060/0x0007; `start` pulse; policy model returns `wp_done` after 4 cycles with `wp_nexthop`=3.
- Required: operands equal the memory values; `wp_nreset` low for exactly 1 cycle; `done` rises 12 cycles after `start`; `nexthop`=3.
REQ-036 Epsilon decay and saturation:
- Stimulus: load 10, step 4; run 3 decisions.
- Required: epsilon 6, then 2, then 0.
REQ-037 Timeout:
- Stimulus: policy model never asserts `wp_done`.
- Required: `timeout_err`=1 and `nexthop`=100 after 255 RUN cycles; epsilon unchanged.
REQ-038 Collisions:
- `start` together with `eps_load` -> epsilon loaded, block stays IDLE.
- `start` during RUN -> ignored, exactly one `done`.
REQ-039 Address mux:
- Stimulus: in RUN, `wp_address`=0x68C.
- Required: `address`=0x68C the same cycle.
REQ-040 Reset mid-RUN:
- Stimulus: reset asserted during RUN.
- Required: `busy`=0, `done` never pulses, `nexthop`=100, epsilon=15.
